// File: rtl/hci_router_wide_adapter.sv
// hci_router_wide_adapter
//
// Upstream stage of the reordering HCI router. A wide NB_CHAN-word
// valid/ready request is captured in a single-entry slice and presented
// to the router as NB_CHAN per-channel requests. The bank rotation
// (order) comes from the word address. The router answers with a fixed
// latency of one cycle and cannot be stalled. Read data is therefore
// buffered in a FIFO, and a read is only issued when a FIFO slot is
// guaranteed for its response.
//
// Ports
//   clk_i, rst_ni, clear_i    clock, async active-low reset, sync flush
//   req_*                     upstream wide request (valid/ready)
//   rsp_*                     upstream read response (valid/ready)
//   rtr_req_o .. rtr_data_o   router request side
//   rtr_r_valid_i, _data_i    router response, one cycle after grant
//   unexp_rsp_o               sticky: response seen with nothing in flight
module hci_router_wide_adapter #(
    parameter int unsigned NB_CHAN    = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [AW-1:0]              req_addr_i,
    input  logic                       req_wen_i,
    input  logic [4*NB_CHAN-1:0]       req_be_i,
    input  logic [32*NB_CHAN-1:0]      req_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [32*NB_CHAN-1:0]      rsp_data_o,
    output logic                       rtr_req_o,
    input  logic                       rtr_gnt_i,
    output logic [$clog2(NB_CHAN)-1:0] rtr_order_o,
    output logic [AW*NB_CHAN-1:0]      rtr_add_o,
    output logic                       rtr_wen_o,
    output logic [4*NB_CHAN-1:0]       rtr_be_o,
    output logic [32*NB_CHAN-1:0]      rtr_data_o,
    input  logic                       rtr_r_valid_i,
    input  logic [32*NB_CHAN-1:0]      rtr_r_data_i,
    output logic                       unexp_rsp_o
);

    localparam int unsigned LOG_NB = $clog2(NB_CHAN);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Input slice
    logic                  r_full;
    logic [AW-1:2]         r_addr;
    logic                  r_wen;
    logic [4*NB_CHAN-1:0]  r_be;
    logic [32*NB_CHAN-1:0] r_data;

    // In-flight tracking and status
    logic r_inflight;
    logic r_inflight_rd;
    logic r_mask;
    logic r_unexp;

    // Response FIFO
    logic [32*NB_CHAN-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic          w_load;
    logic          w_issue;
    logic          w_credit_ok;
    logic [CW:0]   w_used;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read reserves a FIFO slot for its response at issue time: the slot
    // is counted as used from the cycle after issue (inflight_rd) until the
    // response is pushed, so a push can never find the FIFO full.
    assign w_used      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight_rd};
    assign w_credit_ok = ~r_wen | (w_used < (CW+1)'(FIFO_DEPTH));

    assign rtr_req_o   = r_full & w_credit_ok;
    assign w_issue     = rtr_req_o & rtr_gnt_i;
    assign req_ready_o = ~r_full | w_issue;
    assign w_load      = req_valid_i & req_ready_o;

    // The response cycle right after a reset or clear is ignored: it may
    // belong to a request issued before the flush.
    assign w_rsp  = rtr_r_valid_i & ~r_mask;
    assign w_push = w_rsp & r_inflight_rd;
    assign w_pop  = rsp_valid_o & rsp_ready_i;

    // Payload outputs read as zero while the slice is empty.
    assign rtr_order_o = r_full ? r_addr[LOG_NB+1:2] : '0;
    assign rtr_wen_o   = r_full & r_wen;
    assign rtr_be_o    = r_full ? r_be : '0;
    assign rtr_data_o  = r_full ? r_data : '0;

    for (genvar i = 0; i < NB_CHAN; i++) begin : g_add
        assign rtr_add_o[AW*i +: AW] = r_full ? ({r_addr, 2'b00} + AW'(4*i)) : '0;
    end

    assign rsp_valid_o = (r_count != '0);
    assign rsp_data_o  = rsp_valid_o ? r_mem[r_rptr] : '0;
    assign unexp_rsp_o = r_unexp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full        <= 1'b0;
            r_inflight    <= 1'b0;
            r_inflight_rd <= 1'b0;
            r_mask        <= 1'b1;
            r_unexp       <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else if (clear_i) begin
            r_full        <= 1'b0;
            r_inflight    <= 1'b0;
            r_inflight_rd <= 1'b0;
            r_mask        <= 1'b1;
            r_unexp       <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_mask        <= 1'b0;
            if (w_load) begin
                r_full <= 1'b1;
            end else if (w_issue) begin
                r_full <= 1'b0;
            end
            r_inflight    <= w_issue;
            r_inflight_rd <= w_issue & r_wen;
            if (w_rsp & ~r_inflight) begin
                r_unexp <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (~w_push & w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_addr <= req_addr_i[AW-1:2];
            r_wen  <= req_wen_i;
            r_be   <= req_be_i;
            r_data <= req_data_i;
        end
        if (w_push) begin
            r_mem[r_wptr] <= rtr_r_data_i;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && (r_count == CW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_hci_router_wide_adapter.sv
module tb_hci_router_wide_adapter;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam int FD = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_addr_i;
    logic          req_wen_i;
    logic [15:0]   req_be_i;
    logic [127:0]  req_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [127:0]  rsp_data_o;
    logic          rtr_req_o;
    logic          rtr_gnt_i;
    logic [1:0]    rtr_order_o;
    logic [127:0]  rtr_add_o;
    logic          rtr_wen_o;
    logic [15:0]   rtr_be_o;
    logic [127:0]  rtr_data_o;
    logic          rtr_r_valid_i = 1'b0;
    logic [127:0]  rtr_r_data_i = '0;
    logic          unexp_rsp_o;

    hci_router_wide_adapter #(.NB_CHAN(NB), .AW(AW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wen_i(req_wen_i),
        .req_be_i(req_be_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rtr_req_o(rtr_req_o), .rtr_gnt_i(rtr_gnt_i), .rtr_order_o(rtr_order_o),
        .rtr_add_o(rtr_add_o), .rtr_wen_o(rtr_wen_o), .rtr_be_o(rtr_be_o),
        .rtr_data_o(rtr_data_o), .rtr_r_valid_i(rtr_r_valid_i),
        .rtr_r_data_i(rtr_r_data_i), .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc++;

    typedef struct packed {
        logic [31:0]  c;
        logic [31:0]  a;
        logic         w;
        logic [15:0]  be;
        logic [127:0] d;
    } iss_t;

    iss_t         iss_q[$];
    logic [127:0] rsp_q[$];
    int           rsp_c[$];
    logic         pend_v = 1'b0;
    logic [127:0] pend_d = '0;
    logic         inj = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_rd(input logic [31:0] a);
        logic [127:0] r;
        for (int i = 0; i < NB; i++) begin
            r[32*i +: 32] = ({a[31:2], 2'b00} + 32'(4*i)) ^ 32'hCAFE0000;
        end
        return r;
    endfunction

    // Router model: answers every grant one cycle later with data derived
    // from the channel address; inj forces a stray response.
    always @(negedge clk_i) begin
        #1;
        rtr_r_valid_i = pend_v | inj;
        rtr_r_data_i  = pend_d;
        #1;
        pend_v = rtr_req_o & rtr_gnt_i;
        for (int i = 0; i < NB; i++) begin
            pend_d[32*i +: 32] = rtr_add_o[32*i +: 32] ^ 32'hCAFE0000;
        end
        if (pend_v) iss_q.push_back(iss_t'{32'(cyc), rtr_add_o[31:0], rtr_wen_o, rtr_be_o, rtr_data_o});
        if (rsp_valid_o && rsp_ready_i) begin
            rsp_q.push_back(rsp_data_o);
            rsp_c.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [15:0] be, input logic [127:0] d);
        int n = 0;
        logic acc = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wen_i   = w;
        req_be_i    = be;
        req_data_i  = d;
        do begin
            #3;
            acc = req_ready_o;
            @(negedge clk_i);
            n++;
        end while (!acc && n < 50);
        req_valid_i = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int k = 0;
        while (rsp_q.size() < n && k < 40) begin
            @(negedge clk_i);
            #3;
            k++;
        end
        chk(tag, rsp_q.size(), n);
        @(negedge clk_i);
    endtask

    task automatic clr_q();
        iss_q.delete();
        rsp_q.delete();
        rsp_c.delete();
    endtask

    int k0;
    int base;
    int iss_off[4] = '{0, 1, 3, 4};
    int rsp_off[4] = '{2, 3, 5, 6};
    logic [31:0] a2[4] = '{32'h2000, 32'h2010, 32'h2020, 32'h2030};
    logic [31:0] a3[3] = '{32'h3000, 32'h3010, 32'h3020};

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
        req_wen_i = 1'b0; req_be_i = '0; req_data_i = '0; rsp_ready_i = 1'b0; rtr_gnt_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #3;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_req", rtr_req_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_unexp", unexp_rsp_o, 0);
        chk("rst_add", rtr_add_o, 0);
        chk("rst_order", rtr_order_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Single read
        rtr_gnt_i = 1'b1; rsp_ready_i = 1'b1; clr_q();
        send(32'h1008, 1'b1, 16'hFFFF, '0);
        #3;
        chk("t1_req", rtr_req_o, 1);
        chk("t1_ready", req_ready_o, 1);
        chk("t1_order", rtr_order_o, 2);
        chk("t1_add", rtr_add_o, 128'h00001014_00001010_0000100C_00001008);
        @(negedge clk_i);
        wait_rsp(1, "t1_rsp_n");
        if (rsp_q.size() > 0 && iss_q.size() > 0) begin
            chk("t1_data", rsp_q[0], exp_rd(32'h1008));
            chk("t1_lat", rsp_c[0] - int'(iss_q[0].c), 2);
        end
        repeat (3) @(negedge clk_i);

        // Back-to-back reads; credits stall the third by one cycle
        clr_q();
        for (int i = 0; i < 4; i++) send(a2[i], 1'b1, 16'hFFFF, '0);
        wait_rsp(4, "t2_rsp_n");
        repeat (2) @(negedge clk_i);
        chk("t2_iss_n", iss_q.size(), 4);
        if (iss_q.size() == 4 && rsp_q.size() == 4) begin
            base = int'(iss_q[0].c);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_iss_cyc%0d", i), int'(iss_q[i].c) - base, iss_off[i]);
                chk($sformatf("t2_rsp_cyc%0d", i), rsp_c[i] - base, rsp_off[i]);
                chk($sformatf("t2_data%0d", i), rsp_q[i], exp_rd(a2[i]));
            end
        end

        // Backpressure: third read held until a pop frees a credit
        rsp_ready_i = 1'b0; clr_q();
        for (int i = 0; i < 3; i++) send(a3[i], 1'b1, 16'hFFFF, '0);
        repeat (3) @(negedge clk_i);
        #3;
        chk("t3_req_held", rtr_req_o, 0);
        chk("t3_ready", req_ready_o, 0);
        chk("t3_rsp_valid", rsp_valid_o, 1);
        chk("t3_head", rsp_data_o, exp_rd(32'h3000));
        chk("t3_iss_n", iss_q.size(), 2);
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        k0 = cyc;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t3_iss_n2", iss_q.size(), 3);
        if (iss_q.size() == 3) begin
            chk("t3_iss_cyc", int'(iss_q[2].c), k0 + 1);
            chk("t3_iss_addr", iss_q[2].a, 32'h3020);
        end
        rsp_ready_i = 1'b1;
        wait_rsp(3, "t3_rsp_n");
        if (rsp_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("t3_data%0d", i), rsp_q[i], exp_rd(a3[i]));
        end
        repeat (3) @(negedge clk_i);

        // Write then read: only the read answers upstream
        clr_q();
        send(32'h4000, 1'b0, 16'hFFFF, 128'h11112222_33334444_55556666_77778888);
        send(32'h4100, 1'b1, 16'hFFFF, '0);
        wait_rsp(1, "t4_rsp_n");
        repeat (4) @(negedge clk_i);
        chk("t4_rsp_only", rsp_q.size(), 1);
        if (rsp_q.size() > 0) chk("t4_data", rsp_q[0], exp_rd(32'h4100));
        if (iss_q.size() == 2) begin
            chk("t4_wr_wen", iss_q[0].w, 0);
            chk("t4_wr_be", iss_q[0].be, 16'hFFFF);
            chk("t4_wr_data", iss_q[0].d, 128'h11112222_33334444_55556666_77778888);
            chk("t4_rd_wen", iss_q[1].w, 1);
        end else begin
            chk("t4_iss_n", iss_q.size(), 2);
        end

        // Grant withheld for 5 cycles
        rtr_gnt_i = 1'b0; clr_q();
        send(32'h5000, 1'b1, 16'h0F0F, '0);
        for (int i = 0; i < 5; i++) begin
            #3;
            chk($sformatf("t5_req%0d", i), rtr_req_o, 1);
            chk($sformatf("t5_add%0d", i), rtr_add_o, 128'h0000500C_00005008_00005004_00005000);
            chk($sformatf("t5_be%0d", i), rtr_be_o, 16'h0F0F);
            chk($sformatf("t5_ready%0d", i), req_ready_o, 0);
            @(negedge clk_i);
        end
        rtr_gnt_i = 1'b1;
        wait_rsp(1, "t5_rsp_n");
        if (rsp_q.size() > 0) chk("t5_data", rsp_q[0], exp_rd(32'h5000));

        // Address wrap, stray response, clear
        clr_q();
        send(32'hFFFFFFFC, 1'b1, 16'hFFFF, '0);
        #3;
        chk("t6_add0", rtr_add_o[31:0], 32'hFFFFFFFC);
        chk("t6_add1", rtr_add_o[63:32], 32'h0);
        chk("t6_order", rtr_order_o, 3);
        @(negedge clk_i);
        wait_rsp(1, "t6_rsp_n");
        if (rsp_q.size() > 0) chk("t6_data", rsp_q[0], exp_rd(32'hFFFFFFFC));
        repeat (2) @(negedge clk_i);
        #3;
        chk("t6_unexp_idle", unexp_rsp_o, 0);
        @(negedge clk_i);
        inj = 1'b1;
        @(negedge clk_i);
        inj = 1'b0;
        #3;
        chk("t6_unexp_set", unexp_rsp_o, 1);
        repeat (3) @(negedge clk_i);
        #3;
        chk("t6_unexp_sticky", unexp_rsp_o, 1);
        chk("t6_no_rsp", rsp_valid_o, 0);
        @(negedge clk_i);

        // Clear with a read in flight
        clr_q();
        send(32'h6000, 1'b1, 16'hFFFF, '0);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #3;
        chk("t7_unexp_clr", unexp_rsp_o, 0);
        chk("t7_ready", req_ready_o, 1);
        repeat (3) @(negedge clk_i);
        #3;
        chk("t7_unexp_masked", unexp_rsp_o, 0);
        chk("t7_rsp_valid", rsp_valid_o, 0);
        chk("t7_rsp_n", rsp_q.size(), 0);
        chk("t7_iss_n", iss_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
